// File: rtl/spi_sclk_gen_pkg.sv
// spi_pkg: shared state encoding, default widths and constants for spi_sclk_gen.
// Optional feature macro used by this slice: SPI_SCLK_ABORT_EN.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } spi_state_t;

    localparam int SPI_DIV_W     = 8;
    localparam int SPI_CNT_W     = 6;

    // div value giving 8.33 MHz SCLK from clk_50, the nRF24L01 default
    localparam int SPI_DIV_NRF24 = 2;

endpackage

// File: rtl/spi_sclk_gen_if.sv
// spi_sclk_gen_if: control/status bundle between an SPI master and spi_sclk_gen.
// SPI_SCLK_ABORT_EN adds the abort request line.
interface spi_sclk_gen_if
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W,
    parameter int CNT_W = SPI_CNT_W
);
    logic [DIV_W-1:0] div;
    logic             cpol;
    logic             cpha;
    logic [CNT_W-1:0] nbits;
    logic             start;
`ifdef SPI_SCLK_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic             sclk;
    logic             sample_stb;
    logic             shift_stb;

    modport master (
`ifdef SPI_SCLK_ABORT_EN
        output abort,
`endif
        output div, cpol, cpha, nbits, start,
        input  busy, done, sclk, sample_stb, shift_stb
    );

    modport slave (
`ifdef SPI_SCLK_ABORT_EN
        input  abort,
`endif
        input  div, cpol, cpha, nbits, start,
        output busy, done, sclk, sample_stb, shift_stb
    );

endinterface

// File: rtl/spi_sclk_gen_half_period_counter.sv
// spi_half_period_counter: counts 0..i_term while enabled and flags the terminal count.
module spi_half_period_counter
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_term,
    output logic             o_tc
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == i_term);

    // Count up while enabled, wrap to zero on terminal count
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: registered SPI SCLK generator in the clk_50 domain with
// run-time divider, CPOL/CPHA modes, burst length and sample/shift strobes.
// Define SPI_SCLK_ABORT_EN to add the abort input on the interface.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W,
    parameter int CNT_W = SPI_CNT_W
) (
    input  logic          clk_50,
    input  logic          rst,
    spi_sclk_gen_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_TAIL = TAIL;

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_div_l;
    logic             r_cpol_l;
    logic             r_cpha_l;
    logic [CNT_W-1:0] r_nbits_l;
    logic [CNT_W:0]   r_e;
    logic             r_busy;
    logic             r_done;
    logic             r_sclk;
    logic             r_sample;
    logic             r_shift;

    logic             w_tc;
    logic             w_hc_en;
    logic             w_hc_clear;
    logic [CNT_W:0]   w_last_e;
    logic             w_is_sample;

    assign w_hc_en    = (r_state != ST_IDLE);
    assign w_hc_clear = (r_state == ST_IDLE);
    assign w_last_e   = {r_nbits_l, 1'b0} - (CNT_W+1)'(1);
    // Even edges are leading edges; sampling sits on leading for cpha=0, trailing for cpha=1
    assign w_is_sample = (r_e[0] == r_cpha_l);

    spi_half_period_counter #(
        .DIV_W(DIV_W)
    ) u_hpc (
        .i_clk   (clk_50),
        .i_rst   (rst),
        .i_clear (w_hc_clear),
        .i_en    (w_hc_en),
        .i_term  (r_div_l),
        .o_tc    (w_tc)
    );

    // Burst FSM: latch controls on start, toggle SCLK per half-period, emit strobes
    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_div_l   <= '0;
            r_cpol_l  <= 1'b0;
            r_cpha_l  <= 1'b0;
            r_nbits_l <= '0;
            r_e       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sample  <= 1'b0;
            r_shift   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_sample <= 1'b0;
            r_shift  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sclk <= bus.cpol;
                    if (bus.start && (bus.nbits != '0)) begin
                        r_div_l   <= bus.div;
                        r_cpol_l  <= bus.cpol;
                        r_cpha_l  <= bus.cpha;
                        r_nbits_l <= bus.nbits;
                        r_e       <= '0;
                        r_busy    <= 1'b1;
                        r_shift   <= ~bus.cpha;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tc) begin
                        r_sclk <= ~r_sclk;
                        r_e    <= r_e + (CNT_W+1)'(1);
                        if (w_is_sample) begin
                            r_sample <= 1'b1;
                        end else if (r_e != w_last_e) begin
                            r_shift <= 1'b1;
                        end
                        if (r_e == w_last_e) begin
                            r_state <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    r_sclk <= r_cpol_l;
                    if (w_tc) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef SPI_SCLK_ABORT_EN
            // Abort overrides whatever the busy states scheduled this cycle
            if (bus.abort && (r_state != ST_IDLE)) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
                r_sclk   <= r_cpol_l;
                r_sample <= 1'b0;
                r_shift  <= 1'b0;
            end
`endif
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.sclk       = r_sclk;
    assign bus.sample_stb = r_sample;
    assign bus.shift_stb  = r_shift;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: scoreboard bench for spi_sclk_gen. Expected burst summaries
// are pushed when a burst is requested and compared when busy falls.
module tb_spi_sclk_gen;
    import spi_pkg::*;

    localparam int DW = SPI_DIV_W;
    localparam int CW = SPI_CNT_W;

    typedef struct {
        int busy_cyc;
        int edges;
        int rises;
        int s_r;
        int s_f;
        int s_n;
        int h_r;
        int h_f;
        int h_n;
        int dones;
        int first;
        int min_sp;
        int max_sp;
    } exp_t;

    logic clk_50 = 1'b0;
    logic rst    = 1'b1;

    always #10 clk_50 = ~clk_50;

    spi_sclk_gen_if #(.DIV_W(DW), .CNT_W(CW)) bus ();

    spi_sclk_gen #(.DIV_W(DW), .CNT_W(CW)) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    int   tick = 0, n_opened = 0, n_closed = 0, stray = 0;
    int   fall_tick = 0, rise_tick = 0, last_edge = 0, last_gap = 0;
    int   a_busy, a_edges, a_rises, a_sr, a_sf, a_sn, a_hr, a_hf, a_hn, a_done;
    int   a_first, a_min, a_max;
    logic prev_busy = 1'b0;
    logic prev_sclk = 1'b0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s burst=%0d got=%0d want=%0d", tag, n_closed, act, exp);
        end
    endtask

    // Expected burst summary from mode/divider/length; k = edges before the burst ends
    function automatic exp_t model(input int n, input int d, input bit pol, input bit pha,
                                   input int k, input bit full);
        exp_t x;
        bit   lead, rise, smp, shf;
        x = '{default: 0};
        x.edges    = k;
        x.dones    = full ? 1 : 0;
        x.busy_cyc = full ? (2*n+1)*(d+1) : k*(d+1)+1;
        x.first    = (k > 0) ? d+1 : 0;
        x.min_sp   = (k > 1) ? d+1 : 0;
        x.max_sp   = (k > 1) ? d+1 : 0;
        x.h_n      = pha ? 0 : 1;
        for (int e = 0; e < k; e++) begin
            lead = (e % 2 == 0);
            rise = lead ^ pol;
            smp  = (lead != pha);
            shf  = !smp && (e != 2*n-1);
            x.rises += rise ? 1 : 0;
            if (smp) begin
                if (rise) x.s_r++; else x.s_f++;
            end
            if (shf) begin
                if (rise) x.h_r++; else x.h_f++;
            end
        end
        return x;
    endfunction

    // Monitor: accumulate one burst between busy rise and busy fall
    always @(negedge clk_50) begin
        logic w_edge;
        int   sp;
        exp_t x;
        tick++;
        if (bus.busy === 1'b1) begin
            if (!prev_busy) begin
                n_opened++;
                last_gap  = tick - fall_tick;
                rise_tick = tick;
                last_edge = tick;
                a_busy = 0; a_edges = 0; a_rises = 0; a_sr = 0; a_sf = 0; a_sn = 0;
                a_hr = 0; a_hf = 0; a_hn = 0; a_done = 0; a_first = 0; a_min = 0; a_max = 0;
            end
            a_busy++;
            w_edge = (bus.sclk !== prev_sclk);
            if (w_edge) begin
                sp = tick - last_edge;
                if (a_edges == 0) begin
                    a_first = sp;
                end else begin
                    if (a_min == 0 || sp < a_min) a_min = sp;
                    if (sp > a_max) a_max = sp;
                end
                last_edge = tick;
                a_edges++;
                if (bus.sclk === 1'b1) a_rises++;
            end
            if (bus.sample_stb === 1'b1) begin
                if (!w_edge) a_sn++; else if (bus.sclk === 1'b1) a_sr++; else a_sf++;
            end
            if (bus.shift_stb === 1'b1) begin
                if (!w_edge) a_hn++; else if (bus.sclk === 1'b1) a_hr++; else a_hf++;
            end
            if (bus.done === 1'b1) a_done++;
        end else if (prev_busy) begin
            fall_tick = tick;
            if (bus.done === 1'b1) a_done++;
            if (bus.sample_stb === 1'b1 || bus.shift_stb === 1'b1) stray++;
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 1, 0);
            end else begin
                x = sb_q.pop_front();
                check_eq("busy_cycles",  a_busy,  x.busy_cyc);
                check_eq("sclk_edges",   a_edges, x.edges);
                check_eq("sclk_rises",   a_rises, x.rises);
                check_eq("sample_rise",  a_sr,    x.s_r);
                check_eq("sample_fall",  a_sf,    x.s_f);
                check_eq("sample_noedge",a_sn,    x.s_n);
                check_eq("shift_rise",   a_hr,    x.h_r);
                check_eq("shift_fall",   a_hf,    x.h_f);
                check_eq("shift_setup",  a_hn,    x.h_n);
                check_eq("done_pulses",  a_done,  x.dones);
                check_eq("first_edge",   a_first, x.first);
                check_eq("min_spacing",  a_min,   x.min_sp);
                check_eq("max_spacing",  a_max,   x.max_sp);
            end
            n_closed++;
        end else if (bus.done === 1'b1 || bus.sample_stb === 1'b1 || bus.shift_stb === 1'b1) begin
            stray++;
        end
        prev_busy = (bus.busy === 1'b1);
        prev_sclk = bus.sclk;
    end

    task automatic cfg(input int n, input int d, input bit pol, input bit pha);
        bus.nbits = CW'(n);
        bus.div   = DW'(d);
        bus.cpol  = pol;
        bus.cpha  = pha;
        repeat (2) @(negedge clk_50);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk_50);
        bus.start = 1'b0;
    endtask

    task automatic wait_opened(input int target, input int limit);
        int i = 0;
        while (n_opened < target && i < limit) begin
            @(negedge clk_50); #1; i++;
        end
        check_eq("wait_busy_rise", (n_opened >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_closed(input int target, input int limit);
        int i = 0;
        while (n_closed < target && i < limit) begin
            @(negedge clk_50); #1; i++;
        end
        check_eq("wait_busy_fall", (n_closed >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_edges(input int k, input int limit);
        int i = 0;
        while (a_edges < k && i < limit) begin
            @(negedge clk_50); #1; i++;
        end
        check_eq("wait_edges", (a_edges >= k) ? 1 : 0, 1);
    endtask

    initial begin
        int c, o, s;
        bus.start = 1'b0;
        bus.div   = '0;
        bus.cpol  = 1'b0;
        bus.cpha  = 1'b0;
        bus.nbits = '0;
`ifdef SPI_SCLK_ABORT_EN
        bus.abort = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk_50);
        #1;
        check_eq("rst_busy",   bus.busy,       0);
        check_eq("rst_done",   bus.done,       0);
        check_eq("rst_sclk",   bus.sclk,       0);
        check_eq("rst_sample", bus.sample_stb, 0);
        check_eq("rst_shift",  bus.shift_stb,  0);
        rst = 1'b0;

        // Mode 0, nRF24 divider, 8 bits
        sb_q.push_back(model(8, SPI_DIV_NRF24, 1'b0, 1'b0, 16, 1'b1));
        cfg(8, SPI_DIV_NRF24, 1'b0, 1'b0);
        c = n_closed;
        pulse_start();
        wait_closed(c + 1, 200);

        // Mode 3, fastest divider, single bit
        sb_q.push_back(model(1, 0, 1'b1, 1'b1, 2, 1'b1));
        cfg(1, 0, 1'b1, 1'b1);
        check_eq("idle_sclk_cpol1", bus.sclk, 1);
        c = n_closed;
        pulse_start();
        wait_closed(c + 1, 50);

        // nbits=0 request is ignored
        o = n_opened;
        s = stray;
        cfg(0, 1, 1'b0, 1'b0);
        pulse_start();
        repeat (6) @(negedge clk_50);
        #1;
        check_eq("nbits0_no_burst", n_opened, o);
        check_eq("nbits0_no_pulse", stray, s);
        check_eq("nbits0_busy",     bus.busy, 0);

        // start and input changes while busy are ignored
        sb_q.push_back(model(4, 1, 1'b0, 1'b1, 8, 1'b1));
        cfg(4, 1, 1'b0, 1'b1);
        c = n_closed;
        o = n_opened;
        pulse_start();
        wait_opened(o + 1, 10);
        repeat (3) @(negedge clk_50);
        bus.nbits = CW'(9);
        bus.div   = DW'(5);
        bus.cpol  = 1'b1;
        bus.cpha  = 1'b0;
        pulse_start();
        wait_closed(c + 1, 100);
        check_eq("busy_start_ignored", n_opened, o + 1);

        // Reset after the fifth edge aborts without done
        sb_q.push_back(model(8, 2, 1'b0, 1'b0, 5, 1'b0));
        cfg(8, 2, 1'b0, 1'b0);
        c = n_closed;
        o = n_opened;
        pulse_start();
        wait_opened(o + 1, 10);
        wait_edges(5, 100);
        rst = 1'b1;
        @(negedge clk_50);
        #1;
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_sclk", bus.sclk, 0);
        check_eq("midrst_done", bus.done, 0);
        rst = 1'b0;
        check_eq("midrst_closed", n_closed, c + 1);
        sb_q.push_back(model(8, 2, 1'b0, 1'b0, 16, 1'b1));
        cfg(8, 2, 1'b0, 1'b0);
        c = n_closed;
        pulse_start();
        wait_closed(c + 1, 200);

        // Back-to-back with start held: second burst taken in the done cycle
        sb_q.push_back(model(2, 1, 1'b0, 1'b0, 4, 1'b1));
        sb_q.push_back(model(2, 1, 1'b0, 1'b0, 4, 1'b1));
        cfg(2, 1, 1'b0, 1'b0);
        c = n_closed;
        bus.start = 1'b1;
        wait_closed(c + 1, 100);
        @(negedge clk_50);
        #1;
        bus.start = 1'b0;
        check_eq("b2b_busy_again", bus.busy, 1);
        check_eq("b2b_gap", last_gap, 1);
        wait_closed(c + 2, 100);

`ifdef SPI_SCLK_ABORT_EN
        // Abort after three edges: back to cpol_l, no done
        sb_q.push_back(model(8, 2, 1'b1, 1'b0, 3, 1'b0));
        cfg(8, 2, 1'b1, 1'b0);
        c = n_closed;
        o = n_opened;
        pulse_start();
        wait_opened(o + 1, 10);
        wait_edges(3, 100);
        bus.abort = 1'b1;
        @(negedge clk_50);
        #1;
        bus.abort = 1'b0;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_sclk", bus.sclk, 1);
        check_eq("abort_done", bus.done, 0);
        check_eq("abort_closed", n_closed, c + 1);

        // Abort in IDLE does nothing; abort together with start lets start win
        o = n_opened;
        bus.abort = 1'b1;
        repeat (3) @(negedge clk_50);
        bus.abort = 1'b0;
        #1;
        check_eq("abort_idle", n_opened, o);
        sb_q.push_back(model(1, 0, 1'b0, 1'b1, 2, 1'b1));
        cfg(1, 0, 1'b0, 1'b1);
        c = n_closed;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk_50);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        wait_closed(c + 1, 50);
`endif

        repeat (3) @(negedge clk_50);
        #1;
        check_eq("sb_left",      sb_q.size(), 0);
        check_eq("stray_pulses", stray,       0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised SPI serial-clock generator, the successor to the fixed 50→10 MHz divider.
- Runs entirely in the clk_50 domain and drives SCLK as a registered output, not as a derived clock.
- Supports a run-time divider, all four CPOL/CPHA modes, and bursts of 1..2^CNT_W-1 bits with a start/busy/done handshake.
- Emits sample and shift strobes so the nRF24L01 shift register runs on clk_50 alone.

Parameters:
DIV_W, 8, width of the divider input; half-period = div+1 clk_50 cycles.
CNT_W, 6, width of the bit-count input; max burst = 2^CNT_W-1 bits.

Ports:
clk_50  in  1  system clock, 50 MHz.
rst  in  1  synchronous, active-high reset.
div  in  DIV_W  half-period minus 1; latched on start.
cpol  in  1  SCLK idle level; latched on start.
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on start.
nbits  in  CNT_W  bits in the burst; latched on start.
start  in  1  request a burst; honoured only when busy=0.
busy  out  1  burst in progress.
done  out  1  one-cycle pulse at burst completion.
sclk  out  1  SPI clock, registered.
sample_stb  out  1  one-cycle pulse: capture MISO this cycle.
shift_stb  out  1  one-cycle pulse: present the next MOSI bit.

Behaviour:
- Interface: one clock, clk_50. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, sclk=0, sample_stb=0, shift_stb=0, state=IDLE, counters=0. Reset mid-burst aborts it immediately; no done pulse is issued.
- States:
  - IDLE: sclk <= cpol input every cycle (one-cycle lag). If start=1 and nbits!=0, latch div/cpol/cpha/nbits, clear counters, go to RUN, busy=1 from the next cycle. If start=1 and nbits=0, ignore it and stay in IDLE.
  - RUN: half-period counter hc counts 0..div_l. When hc==div_l, toggle sclk, clear hc and increment the edge index e (0..2*nbits_l-1). After edge e = 2*nbits_l-1, go to TAIL.
  - TAIL: sclk held at cpol_l for one further half-period (div_l+1 cycles). Then go to IDLE, busy=0 and done=1 in the same cycle.
- Timing:
  - First edge occurs div_l+1 cycles after busy rises; successive edges are spaced div_l+1 cycles apart.
  - Total busy time = (2*nbits_l+1)*(div_l+1) cycles.
- Strobes are asserted in the same cycle as the sclk toggle they belong to:
  - cpha=0: shift_stb also pulses in the first busy cycle (first-bit setup). sample_stb on even e; shift_stb on odd e, except the final edge.
  - cpha=1: shift_stb on even e; sample_stb on odd e.
  - Each burst gives exactly nbits_l sample_stb pulses and exactly nbits_l shift_stb pulses.
- div=0 gives sclk = 25 MHz; div=2 gives 8.33 MHz, the nRF24L01 default (≤10 MHz).
- start while busy=1 is ignored. start in the done cycle is accepted, because state is already IDLE.
- Input changes while busy have no effect, since all controls are latched.
- e and hc never wrap within a burst. Terminal comparisons use the latched values only.

Optional Feature:
SPI_SCLK_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 while busy forces the next cycle to IDLE with sclk=cpol_l and busy=0. No done pulse and no further strobes are issued. abort in IDLE is ignored. If abort and start are asserted in the same IDLE cycle, start wins.
- Undefined: the port is absent and bursts always run to completion.

Decomposition:
- Package spi_pkg holds:
  - state enum {IDLE, RUN, TAIL};
  - default widths SPI_DIV_W=8 and SPI_CNT_W=6;
  - constant SPI_DIV_NRF24=2.
- Sub-module spi_half_period_counter: load/clear, count, terminal-count pulse; parametrised by DIV_W and reused by future multi-rate SPI masters.

Test Plan:
1. Reset, then cpol=0, div=2, cpha=0, nbits=8, start -> busy for 51 cycles; sclk has 8 rising edges spaced 6 cycles apart; 8 sample_stb pulses on rising edges; 8 shift_stb pulses (setup cycle + 7 falling edges); single done pulse.
2. Mode 3 (cpol=1, cpha=1), div=0, nbits=1 -> sclk idles at 1; 2 edges; busy for 3 cycles; shift_stb on the falling edge, sample_stb on the rising edge; done once.
3. nbits=0 with start -> busy stays 0, no strobes, no done; start pulsed during busy -> no change to edge count.
4. rst asserted after edge 5 of an 8-bit burst -> next cycle busy=0, sclk=0, no done; a new start then gives a full clean burst.
5. Back-to-back: start held high -> second burst accepted in the done cycle; busy falls for exactly that one cycle.
6. SPI_SCLK_ABORT_EN defined: abort at edge 3 -> IDLE next cycle, sclk=cpol_l, no done, strobe counts are 2 sample / 2 shift (cpha=0).
